// File: rtl/irq_timer_ctrl_if.sv
// Data-memory bus slice seen by the timer/interrupt peripheral.
// master = CPU side, slave = peripheral side.
interface irq_timer_ctrl_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_wr;
  logic        mem_rd;
  logic [31:0] rdata;

  modport master (output addr, output wdata, output mem_wr, output mem_rd, input rdata);
  modport slave  (input addr, input wdata, input mem_wr, input mem_rd, output rdata);
endinterface

// File: rtl/irq_timer_ctrl.sv
// Memory-mapped reloadable 32-bit timer plus edge-latched external interrupts,
// merged into one prioritized, maskable, registered request for the CPU.
module irq_timer_ctrl #(
  parameter logic [31:0] BASE = 32'h4000_0000,
  parameter int unsigned NSRC = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  irq_timer_ctrl_if.slave     bus,
  input  logic [NSRC-1:0]     ext_irq,
  output logic                irq
);

  localparam int unsigned NP = NSRC + 1;

  typedef enum logic [2:0] {
    REG_TH    = 3'd0,
    REG_TL    = 3'd1,
    REG_TCON  = 3'd2,
    REG_PEND  = 3'd3,
    REG_MASK  = 3'd4,
    REG_CAUSE = 3'd5
  } reg_e;

  logic [31:0]     th_q, th_d;
  logic [31:0]     tl_q, tl_d;
  logic            en_q, en_d;
  logic            ien_q, ien_d;
  logic            tstat_q, tstat_d;
  logic [NP-1:0]   pend_q, pend_d;
  logic [NP-1:0]   mask_q, mask_d;
  logic [NSRC-1:0] sync1_q, sync2_q, sync3_q;
  logic            irq_q, irq_d;

  logic            hit;
  reg_e            idx;
  logic            we;
  logic            ovf;
  logic [NSRC-1:0] ext_rise;
  logic [NP-1:0]   active;
  logic [NP-1:0]   w1c;
  logic [4:0]      cause;

  always_comb begin
    hit      = (bus.addr[31:5] == BASE[31:5]) && (bus.addr[4:2] <= 3'd5);
    idx      = reg_e'(bus.addr[4:2]);
    we       = hit && bus.mem_wr;
    ovf      = en_q && (tl_q == '1);
    ext_rise = sync2_q & ~sync3_q;
    active   = pend_q & mask_q;
    w1c      = (we && idx == REG_PEND) ? bus.wdata[NP-1:0] : '0;
    // Scan from the top down so the lowest-numbered active source wins.
    cause = 5'h1F;
    for (int unsigned i = 0; i < NP; i++) begin
      if (active[NP-1-i]) cause = 5'(NP-1-i);
    end
  end

  always_comb begin
    th_d    = th_q;
    tl_d    = tl_q;
    en_d    = en_q;
    ien_d   = ien_q;
    tstat_d = tstat_q;
    mask_d  = mask_q;

    if (en_q) tl_d = ovf ? th_q : tl_q + 32'd1;

    if (we) begin
      unique case (idx)
        REG_TH:   th_d = bus.wdata;
        REG_TL:   tl_d = bus.wdata;
        REG_TCON: begin
          en_d  = bus.wdata[0];
          ien_d = bus.wdata[1];
          if (bus.wdata[2]) tstat_d = 1'b0;
        end
        REG_MASK: mask_d = bus.wdata[NP-1:0];
        default:  ;
      endcase
    end

    // Hardware sets are applied last so they win over a same-cycle clear.
    if (ovf) tstat_d = 1'b1;
    pend_d = (pend_q & ~w1c) | {ext_rise, ovf && ien_q};
    irq_d  = |active;
  end

  always_comb begin
    bus.rdata = '0;
    if (bus.mem_rd && hit) begin
      unique case (idx)
        REG_TH:    bus.rdata = th_q;
        REG_TL:    bus.rdata = tl_q;
        REG_TCON:  bus.rdata = {29'd0, tstat_q, ien_q, en_q};
        REG_PEND:  bus.rdata = 32'(pend_q);
        REG_MASK:  bus.rdata = 32'(mask_q);
        REG_CAUSE: bus.rdata = 32'(cause);
        default:   bus.rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      th_q    <= '0;
      tl_q    <= '0;
      en_q    <= 1'b0;
      ien_q   <= 1'b0;
      tstat_q <= 1'b0;
      pend_q  <= '0;
      mask_q  <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      th_q    <= th_d;
      tl_q    <= tl_d;
      en_q    <= en_d;
      ien_q   <= ien_d;
      tstat_q <= tstat_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      sync1_q <= ext_irq;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      irq_q   <= irq_d;
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_irq_timer_ctrl.sv
// Bench for irq_timer_ctrl: directed scenarios plus a randomized run against
// a register-level reference model.
`timescale 1ns/100ps
module tb_irq_timer_ctrl;

  localparam logic [31:0] BASE   = 32'h4000_0000;
  localparam logic [31:0] A_TH   = BASE + 32'h00;
  localparam logic [31:0] A_TL   = BASE + 32'h04;
  localparam logic [31:0] A_TCON = BASE + 32'h08;
  localparam logic [31:0] A_PEND = BASE + 32'h0C;
  localparam logic [31:0] A_MASK = BASE + 32'h10;
  localparam logic [31:0] A_CAUS = BASE + 32'h14;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] ext_irq = '0;
  logic       irq;
  int         checks = 0;
  int         failures = 0;

  irq_timer_ctrl_if bus ();

  irq_timer_ctrl #(.BASE(BASE), .NSRC(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .ext_irq (ext_irq),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  // Reference model: architectural registers plus a history of ext_irq samples
  // (hist[0] = value captured at the most recent edge).
  bit [31:0] m_th, m_tl;
  bit        m_en, m_ien, m_tstat, m_irq;
  bit [4:0]  m_pend, m_mask;
  bit [3:0]  hist [3];

  task automatic model_reset();
    m_th = 0; m_tl = 0; m_en = 0; m_ien = 0; m_tstat = 0; m_irq = 0;
    m_pend = 0; m_mask = 0;
    for (int i = 0; i < 3; i++) hist[i] = 0;
  endtask

  function automatic int reg_index(input logic [31:0] a);
    logic [31:0] off;
    off = (a & 32'hFFFF_FFFC) - BASE;
    return (off < 32'd24) ? int'(off / 4) : -1;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic rd);
    int ri;
    int c;
    if (!rd) return 32'd0;
    ri = reg_index(a);
    c = 31;
    for (int i = 4; i >= 0; i--) if (m_pend[i] && m_mask[i]) c = i;
    case (ri)
      0: return m_th;
      1: return m_tl;
      2: return {29'd0, m_tstat, m_ien, m_en};
      3: return {27'd0, m_pend};
      4: return {27'd0, m_mask};
      5: return c;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step(input logic [31:0] a, input logic [31:0] d, input logic wr,
                            input logic [3:0] ext);
    int ri;
    bit ovf;
    bit [31:0] tl_n;
    bit [4:0]  pend_n;
    bit        tstat_n;
    ri      = wr ? reg_index(a) : -1;
    ovf     = m_en && (m_tl == 32'hFFFF_FFFF);
    m_irq   = (m_pend & m_mask) != 0;
    tl_n    = m_en ? (ovf ? m_th : m_tl + 1) : m_tl;
    pend_n  = m_pend;
    tstat_n = m_tstat;
    if (ri == 1) tl_n = d;
    if (ri == 3) pend_n = pend_n & ~d[4:0];
    if (ri == 2 && d[2]) tstat_n = 0;
    for (int i = 0; i < 4; i++) if (hist[1][i] && !hist[2][i]) pend_n[i+1] = 1;
    if (ovf) begin
      tstat_n = 1;
      if (m_ien) pend_n[0] = 1;
    end
    if (ri == 0) m_th = d;
    if (ri == 2) begin m_en = d[0]; m_ien = d[1]; end
    if (ri == 4) m_mask = d[4:0];
    m_tl = tl_n; m_pend = pend_n; m_tstat = tstat_n;
    hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = ext;
  endtask

  task automatic tick();
    if (rst_n) model_step(bus.addr, bus.wdata, bus.mem_wr, ext_irq);
    else model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.addr = a; bus.wdata = d; bus.mem_wr = 1'b1;
    tick();
    bus.mem_wr = 1'b0; bus.addr = '0; bus.wdata = '0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.addr = a; bus.mem_rd = 1'b1;
    #1;
    d = bus.rdata;
    bus.mem_rd = 1'b0; bus.addr = '0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    model_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq: got %b want 0", irq); end
    rd(A_CAUS, v);
    checks++; if (v !== 32'h1F) begin failures++; $display("FAIL reset_cause: got %h want 0000001f", v); end
    wr(A_MASK, 32'h1); wr(A_TL, 32'hFFFF_FFFF); wr(A_TCON, 32'h3);
    tick(); tick(); tick();
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL pre_reset_irq: got %b want 1", irq); end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL midcount_reset_irq: got %b want 0", irq); end
    rd(A_TL, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL midcount_reset_tl: got %h want 00000000", v); end
    rd(A_CAUS, v);
    checks++; if (v !== 32'h1F) begin failures++; $display("FAIL midcount_reset_cause: got %h want 0000001f", v); end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_timer();
    logic [31:0] v;
    wr(A_TH, 32'hFFFF_FFFC); wr(A_TL, 32'hFFFF_FFFE); wr(A_MASK, 32'h1); wr(A_TCON, 32'h3);
    tick();
    rd(A_TL, v);
    checks++; if (v !== 32'hFFFF_FFFF) begin failures++; $display("FAIL timer_tl_ff: got %h want ffffffff", v); end
    tick();
    rd(A_TL, v);
    checks++; if (v !== 32'hFFFF_FFFC) begin failures++; $display("FAIL timer_reload: got %h want fffffffc", v); end
    rd(A_PEND, v);
    checks++; if (v !== 32'h1) begin failures++; $display("FAIL timer_pend: got %h want 00000001", v); end
    rd(A_TCON, v);
    checks++; if (v !== 32'h7) begin failures++; $display("FAIL timer_tcon: got %h want 00000007", v); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL timer_irq_early: got %b want 0", irq); end
    tick();
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL timer_irq: got %b want 1", irq); end
    rd(A_CAUS, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL timer_cause: got %h want 00000000", v); end
  endtask

  task automatic test_clear();
    logic [31:0] v;
    wr(A_PEND, 32'h1);
    rd(A_PEND, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL clear_pend: got %h want 00000000", v); end
    wr(A_TCON, 32'h7);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL clear_irq: got %b want 0", irq); end
    rd(A_TCON, v);
    checks++; if (v !== 32'h3) begin failures++; $display("FAIL clear_tstat: got %h want 00000003", v); end
    tick();
    rd(A_PEND, v);
    checks++; if (v !== 32'h1) begin failures++; $display("FAIL clear_repend: got %h want 00000001", v); end
    wr(A_TCON, 32'h4); wr(A_PEND, 32'h1F);
    tick();
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL clear_idle_irq: got %b want 0", irq); end
  endtask

  task automatic test_ext_edge();
    logic [31:0] v;
    wr(A_MASK, 32'h1F);
    ext_irq = 4'b0100;
    tick(); tick();
    rd(A_PEND, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL ext_pend_early: got %h want 00000000", v); end
    tick();
    rd(A_PEND, v);
    checks++; if (v !== 32'h8) begin failures++; $display("FAIL ext_pend: got %h want 00000008", v); end
    rd(A_CAUS, v);
    checks++; if (v !== 32'h3) begin failures++; $display("FAIL ext_cause: got %h want 00000003", v); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL ext_irq_early: got %b want 0", irq); end
    ext_irq = 4'b0000;
    tick();
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL ext_irq: got %b want 1", irq); end
    wr(A_PEND, 32'h8);
    tick();
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL ext_irq_drop: got %b want 0", irq); end
    ext_irq = 4'b0100;
    tick(); tick(); tick();
    wr(A_PEND, 32'h8);
    tick(); tick(); tick(); tick();
    rd(A_PEND, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL ext_level_retrigger: got %h want 00000000", v); end
    ext_irq = 4'b0000;
    tick(); tick(); tick();
  endtask

  task automatic test_priority_mask();
    logic [31:0] v;
    ext_irq = 4'b0100;
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TCON, 32'h3);
    tick();
    wr(A_TCON, 32'h0);
    wr(A_MASK, 32'h08);
    rd(A_CAUS, v);
    checks++; if (v !== 32'h3) begin failures++; $display("FAIL prio_cause: got %h want 00000003", v); end
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL prio_irq: got %b want 1", irq); end
    wr(A_MASK, 32'h0);
    tick();
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL mask_irq: got %b want 0", irq); end
    rd(A_PEND, v);
    checks++; if (v !== 32'h9) begin failures++; $display("FAIL mask_pend: got %h want 00000009", v); end
    rd(A_CAUS, v);
    checks++; if (v !== 32'h1F) begin failures++; $display("FAIL mask_cause: got %h want 0000001f", v); end
    wr(A_PEND, 32'h1F);
    ext_irq = 4'b0000;
    tick(); tick(); tick();
  endtask

  task automatic test_collisions();
    logic [31:0] v;
    wr(A_MASK, 32'h1F);
    ext_irq = 4'b0001;
    tick(); tick();
    wr(A_PEND, 32'h2);
    rd(A_PEND, v);
    checks++; if (v !== 32'h2) begin failures++; $display("FAIL coll_w1c_set: got %h want 00000002", v); end
    ext_irq = 4'b0000;
    wr(A_PEND, 32'h1F);
    tick(); tick();
    wr(A_TCON, 32'h4); wr(A_TL, 32'hFFFF_FFFE); wr(A_TCON, 32'h1);
    tick();
    wr(A_TL, 32'h10);
    rd(A_TL, v);
    checks++; if (v !== 32'h10) begin failures++; $display("FAIL coll_tl_write: got %h want 00000010", v); end
    rd(A_TCON, v);
    checks++; if (v !== 32'h5) begin failures++; $display("FAIL coll_tstat: got %h want 00000005", v); end
    tick();
    rd(A_TL, v);
    checks++; if (v !== 32'h11) begin failures++; $display("FAIL coll_tl_next: got %h want 00000011", v); end
    wr(A_TCON, 32'h4);
    wr(A_TH, 32'h1234_5678); wr(A_MASK, 32'h15);
    wr(32'h4000_0020, 32'hFFFF_FFFF);
    rd(A_TH, v);
    checks++; if (v !== 32'h1234_5678) begin failures++; $display("FAIL unmapped_th: got %h want 12345678", v); end
    rd(A_TL, v);
    checks++; if (v !== 32'h12) begin failures++; $display("FAIL unmapped_tl: got %h want 00000012", v); end
    rd(A_MASK, v);
    checks++; if (v !== 32'h15) begin failures++; $display("FAIL unmapped_mask: got %h want 00000015", v); end
    rd(A_TCON, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL unmapped_tcon: got %h want 00000000", v); end
    rd(BASE + 32'h18, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL unmapped_read: got %h want 00000000", v); end
  endtask

  task automatic test_random();
    logic [31:0] v, a, exp;
    logic        r;
    for (int n = 0; n < 800; n++) begin
      checks++;
      if (irq !== m_irq) begin failures++; $display("FAIL rand_irq cyc %0d: got %b want %b", n, irq, m_irq); end
      if ($urandom_range(7) == 0) a = $urandom;
      else a = BASE + ($urandom_range(7) << 2) + $urandom_range(3);
      r = ($urandom_range(4) != 0);
      bus.addr = a; bus.mem_rd = r;
      #1;
      v = bus.rdata;
      exp = model_read(a, r);
      bus.mem_rd = 1'b0;
      checks++;
      if (v !== exp) begin failures++; $display("FAIL rand_rdata cyc %0d addr %h: got %h want %h", n, a, v, exp); end
      if ($urandom_range(3) == 0) ext_irq[$urandom_range(3)] ^= 1'b1;
      if ($urandom_range(2) == 0) begin
        bus.addr   = ($urandom_range(9) == 0) ? BASE + 32'h20 : BASE + ($urandom_range(5) << 2);
        bus.wdata  = $urandom;
        if (bus.addr == A_TL && $urandom_range(1) == 1) bus.wdata = 32'hFFFF_FFF0 + $urandom_range(15);
        if (bus.addr == A_TH && $urandom_range(1) == 1) bus.wdata = 32'hFFFF_FFF8 + $urandom_range(7);
        bus.mem_wr = 1'b1;
      end
      tick();
      bus.mem_wr = 1'b0;
    end
  endtask

  initial begin
    bus.addr = '0; bus.wdata = '0; bus.mem_wr = 1'b0; bus.mem_rd = 1'b0;
    test_reset();
    test_timer();
    test_clear();
    test_ext_edge();
    test_priority_mask();
    test_collisions();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_timer_ctrl.md
# irq_timer_ctrl

Memory-mapped timer and interrupt controller that produces the single `irq` input of the MIPS control unit. It is placed on the data-memory bus beside the RAM. It decodes word addresses in a small peripheral window, runs a reloadable 32-bit timer, and latches edges from external interrupt lines into pending bits. It then drives one prioritized, maskable request to the CPU. Kernel-mode gating (no interrupt while `pc[31]` is set) stays in the CPU; this block only raises and holds the request until software clears it.

## Interface
- `BASE`, 32'h4000_0000, base byte address of the register window
- `NSRC`, 4, number of external interrupt lines (sources 1..NSRC; source 0 is the timer)

- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `addr`  in  32  byte address from ALU result (bits [1:0] ignored)
- `wdata`  in  32  store data
- `mem_wr`  in  1  store strobe, one cycle per store
- `mem_rd`  in  1  load strobe
- `rdata`  out  32  load data, combinational
- `ext_irq`  in  NSRC  asynchronous external interrupt lines, rising-edge sensitive
- `irq`  out  1  registered interrupt request to control unit

## Operation
- Register map (offset from BASE):
  - 0x00 TH: reload value, RW.
  - 0x04 TL: counter, RW.
  - 0x08 TCON: bit0 EN, bit1 IEN (both RW); bit2 TSTAT (read; write 1 clears).
  - 0x0C PEND: bits [NSRC:0], read; write 1 clears the corresponding bit.
  - 0x10 MASK: bits [NSRC:0], RW.
  - 0x14 CAUSE: read-only. Index of the lowest-numbered bit set in PEND&MASK, or 0x1F when none is set.
- A register is selected only when `addr[31:5]==BASE[31:5]` and `addr[4:2]` ≤ 5. Writes to any other address are ignored. Reads of unmapped offsets and reads outside the window return 0.
- `rdata` = selected register when `mem_rd`, else 0. Unused upper bits read 0.
- Timer:
  - When EN=1, TL increments by 1 every cycle.
  - When TL==32'hFFFF_FFFF with EN=1, the next TL value is TH (overflow event) and TSTAT is set.
  - If IEN=1 at the overflow, PEND[0] is also set.
  - EN=0 freezes TL.
  - Wrap uses modulo-2^32 arithmetic; there is no carry out.
- External lines:
  - Each `ext_irq[i]` passes through a 2-flop synchronizer, then a third flop for edge detection.
  - A synchronized 0→1 edge sets PEND[i+1]. Levels that stay high do not re-trigger.
- Request: `irq` <= |(PEND & MASK) on every clock. Software clears the request by write-1-clear to PEND. Changing MASK takes effect the next cycle.
- Simultaneous events:
  - A hardware set and a software clear of the same PEND bit or TSTAT in the same cycle: the set wins, and the bit remains 1.
  - A software write to TL in the same cycle as an overflow: the write value is loaded and the reload does not happen. TSTAT and PEND[0] are still set per IEN.
  - A write to TCON that sets EN: counting starts the following cycle.
- Reset: while `rst_n`=0, all of these are 0: TH, TL, TCON, PEND, MASK, the synchronizer and edge flops, and `irq`. CAUSE reads 0x1F. Reset may be asserted at any time, including mid-count, and takes effect immediately.

## Timing
- Store: a register updates at the rising edge where `mem_wr`=1. The new value is readable in the next cycle.
- Load: combinational in the same cycle as `mem_rd`.
- Timer overflow at edge k (TL goes to TH): PEND[0] is visible after edge k, and `irq` rises after edge k+1.
- External edge: with `ext_irq` rising before edge n, PEND is set after edge n+2 and `irq` is high after edge n+3. Worst-case latency is 4 cycles.
- Clearing PEND at edge m drops `irq` after edge m+1, provided no other masked source is pending.
- Minimum `ext_irq` high or low width is 2 clocks. Shorter pulses may be lost.

## Test plan
- Reset: assert `rst_n`=0 mid-count → `irq`=0, TL=0. A load of 0x4000_0014 returns 0x1F.
- Timer:
  - Setup: TH=0xFFFF_FFFC, TL=0xFFFF_FFFE, MASK=1, TCON=3.
  - Expected: TL reads FFFF_FFFF and then FFFF_FFFC. PEND=1 and TCON=0x7. `irq` rises 1 cycle after PEND. CAUSE=0.
- Clear: write PEND=1 and TCON=0x7 → `irq` drops next cycle. With TH=0xFFFF_FFFC, PEND[0] sets again after 4 cycles.
- External edge: MASK=0x1F, pulse `ext_irq[2]` high for 3 clocks → PEND=0x08 and CAUSE=3. `irq` goes high 4 cycles after the edge. Holding the line high causes no re-set after clear.
- Priority and mask: pend sources 0 and 3 with MASK=0x08 → CAUSE=3 and `irq`=1. Set MASK=0 → `irq`=0 next cycle, while PEND still reads 0x09.
- Collisions:
  - A W1C to PEND in the same cycle as an ext edge set → the bit stays 1.
  - A TL write of 0x10 at the overflow cycle → TL=0x11 next cycle, TSTAT=1.
  - A store to 0x4000_0020 → no register changes.
